// File: rtl/nes_receiver_if.sv
// ---------------------------------------------------------------------------
// nes_receiver_if
// Signal bundle between the NES gamepad receiver and the rest of the system.
//   poll_req            : request one read of the pad (into the receiver)
//   nes_data            : raw serial data from the pad, active-low (into the receiver)
//   nes_latch, nes_clk  : latch strobe and shift clock driven to the pad
//   buttons[7:0]        : active-high button word
//                         [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   up/down/left/right  : direction strobes; an opposing pair pressed together reads as neither
//   attack              : copy of button A
//   valid               : one-cycle pulse when buttons and strobes update
//   busy                : a poll is in progress
// The master modport is the receiver. The slave modport is the system and pad side.
// ---------------------------------------------------------------------------
interface nes_receiver_if;
  logic       poll_req;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       attack;
  logic       valid;
  logic       busy;

  modport master (
    input  poll_req, nes_data,
    output nes_latch, nes_clk, buttons, up, down, left, right, attack, valid, busy
  );

  modport slave (
    output poll_req, nes_data,
    input  nes_latch, nes_clk, buttons, up, down, left, right, attack, valid, busy
  );
endinterface

// File: rtl/nes_receiver.sv
// ---------------------------------------------------------------------------
// nes_receiver
// Serial front end for a standard NES gamepad. Each accepted poll_req runs
// one read of the pad:
//   1. Raise nes_latch for LATCH_CYCLES cycles.
//   2. Run a low phase and sample bit 0 (A) at its end.
//   3. Run 7 nes_clk high/low pulses of HALF_PERIOD cycles per phase. Each
//      high phase samples the next bit at its end.
//   4. Publish the button word and the decoded strobes in one DONE cycle
//      with a one-cycle valid pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset. It drops any transaction in flight
//           and clears all outputs.
//   bus   : nes_receiver_if.master (poll_req, nes_data in; pad lines,
//           button word, strobes, valid and busy out)
// ---------------------------------------------------------------------------
module nes_receiver #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_PERIOD  = 150
) (
  input  logic           clk,
  input  logic           rst_n,
  nes_receiver_if.master bus
);

  localparam int MAX_CYC = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic attack;
  } dec_t;

  state_e        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [2:0]    idx_q,     idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic [1:0]    sync_q,    sync_d;
  logic          latch_q,   latch_d;
  logic          nclk_q,    nclk_d;
  logic [7:0]    buttons_q, buttons_d;
  dec_t          dec_q,     dec_d;
  logic          valid_q,   valid_d;
  logic          busy_q,    busy_d;

  logic sync_data;
  logic cnt_last_latch;
  logic cnt_last_half;

  // nes_data comes from the pad with no relation to clk. The sampling logic
  // only ever sees the second synchroniser stage.
  assign sync_d         = {sync_q[0], bus.nes_data};
  assign sync_data      = sync_q[1];
  assign cnt_last_latch = (cnt_q == LATCH_LAST);
  assign cnt_last_half  = (cnt_q == HALF_LAST);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    nclk_d    = nclk_q;
    buttons_d = buttons_q;
    dec_d     = dec_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.poll_req) begin
          state_d = S_LATCH;
          latch_d = 1'b1;
          busy_d  = 1'b1;
          shift_d = '0;
        end
      end

      S_LATCH: begin
        if (cnt_last_latch) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          latch_d = 1'b0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LOW: begin
        if (cnt_last_half) begin
          cnt_d = '0;
          if (idx_q == 3'd0) begin
            // Bit 0 (A) is presented by the pad right after the latch, so it
            // is taken at the end of the first low phase. There is no clock
            // pulse before it.
            shift_d[0] = ~sync_data;
            idx_d      = 3'd1;
            nclk_d     = 1'b1;
            state_d    = S_HIGH;
          end else if (idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            nclk_d  = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HIGH: begin
        if (cnt_last_half) begin
          cnt_d          = '0;
          shift_d[idx_q] = ~sync_data;
          nclk_d         = 1'b0;
          state_d        = S_LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        // Opposing directions cancel in the strobes only. The raw button
        // word keeps both bits.
        buttons_d    = shift_q;
        dec_d.up     = shift_q[4] & ~shift_q[5];
        dec_d.down   = shift_q[5] & ~shift_q[4];
        dec_d.left   = shift_q[6] & ~shift_q[7];
        dec_d.right  = shift_q[7] & ~shift_q[6];
        dec_d.attack = shift_q[0];
        valid_d      = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        latch_d = 1'b0;
        nclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every flop samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      sync_q    <= '0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      buttons_q <= '0;
      dec_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      sync_q    <= sync_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      buttons_q <= buttons_d;
      dec_q     <= dec_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.nes_latch = latch_q;
  assign bus.nes_clk   = nclk_q;
  assign bus.buttons   = buttons_q;
  assign bus.up        = dec_q.up;
  assign bus.down      = dec_q.down;
  assign bus.left      = dec_q.left;
  assign bus.right     = dec_q.right;
  assign bus.attack    = dec_q.attack;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nes_receiver.sv
// ---------------------------------------------------------------------------
// tb_nes_receiver
// Drives nes_receiver with LATCH_CYCLES=4 and HALF_PERIOD=2. A behavioural
// pad model serves the button bits. Checks cover timing, the button word and
// the decoded strobes. Expected values come from a table, from hand-written
// sequences, and from a reference function for the randomized polls.
// The pad model presents bit 0 while nes_latch is high. It advances one bit
// at the start of every low phase, when nes_latch or nes_clk falls. Each
// bit is then stable for a whole phase before the receiver samples it
// through its synchroniser. After bit 7 the pad reads as idle-high, and so
// does a disconnected pad.
// ---------------------------------------------------------------------------
module tb_nes_receiver;

  localparam int L   = 4;
  localparam int H   = 2;
  localparam int LAT = L + 15 * H + 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  nes_receiver_if bus ();

  nes_receiver #(.LATCH_CYCLES(L), .HALF_PERIOD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- pad model ----------------
  logic [7:0] pad_bits = 8'h00;
  bit         pad_conn = 1'b1;
  int         pad_idx  = 0;

  always @(posedge bus.nes_latch or negedge bus.nes_latch or negedge bus.nes_clk) begin
    if (bus.nes_latch) pad_idx = 0;
    else if (pad_idx < 8) pad_idx = pad_idx + 1;
  end

  assign bus.nes_data = (pad_conn && pad_idx < 8) ? ~pad_bits[pad_idx[2:0]] : 1'b1;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] buttons;
    logic       up, down, left, right, attack;
  } result_t;

  function automatic result_t ref_result(input logic [7:0] pressed, input bit conn);
    result_t r;
    r.buttons = conn ? pressed : 8'h00;
    r.up      = r.buttons[4] && !r.buttons[5];
    r.down    = r.buttons[5] && !r.buttons[4];
    r.left    = r.buttons[6] && !r.buttons[7];
    r.right   = r.buttons[7] && !r.buttons[6];
    r.attack  = r.buttons[0];
    return r;
  endfunction

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic result_t observed();
    result_t r;
    r.buttons = bus.buttons;
    r.up      = bus.up;
    r.down    = bus.down;
    r.left    = bus.left;
    r.right   = bus.right;
    r.attack  = bus.attack;
    return r;
  endfunction

  // Caller is at a negedge with the receiver idle. On return we are at the
  // negedge where valid is high, or where the wait bound ran out.
  task automatic run_poll(input string tag, input logic [7:0] bits, input bit conn);
    int         lat, latch_n, rise_n, high_n, hold_bad;
    logic       prev_clk;
    logic [7:0] prev_btn;
    lat = 0; latch_n = 0; rise_n = 0; high_n = 0; hold_bad = 0;
    prev_clk = 1'b0;
    prev_btn = bus.buttons;
    pad_bits = bits;
    pad_conn = conn;
    bus.poll_req = 1'b1;
    @(negedge clk);
    bus.poll_req = 1'b0;
    while (!bus.valid && lat < 200) begin
      if (bus.nes_latch) latch_n++;
      if (bus.nes_clk) high_n++;
      if (bus.nes_clk && !prev_clk) rise_n++;
      prev_clk = bus.nes_clk;
      if (bus.buttons !== prev_btn) hold_bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_latch_cycles"}, latch_n, L);
    check({tag, "_clk_pulses"}, rise_n, 7);
    check({tag, "_clk_high_cycles"}, high_n, 7 * H);
    check({tag, "_hold_before_valid"}, hold_bad, 0);
    check({tag, "_busy_at_valid"}, bus.busy, 0);
  endtask

  typedef struct {
    logic [7:0] pad;
    bit         conn;
    logic [7:0] exp_buttons;
    logic [4:0] exp_dec;   // {up, down, left, right, attack}
  } vec_t;

  vec_t vecs[8];

  initial begin
    result_t exp_r, got_r;
    int      n_valid, n_rise, n_idle, guard;
    logic    prev_latch;

    vecs[0] = '{8'h81, 1'b1, 8'h81, 5'b00011};  // A + Right
    vecs[1] = '{8'h70, 1'b1, 8'h70, 5'b00100};  // Up + Down + Left
    vecs[2] = '{8'hFF, 1'b0, 8'h00, 5'b00000};  // no pad
    vecs[3] = '{8'hC0, 1'b1, 8'hC0, 5'b00000};  // Left + Right
    vecs[4] = '{8'h11, 1'b1, 8'h11, 5'b10001};  // A + Up
    vecs[5] = '{8'h24, 1'b1, 8'h24, 5'b01000};  // Select + Down
    vecs[6] = '{8'hFF, 1'b1, 8'hFF, 5'b00001};  // everything
    vecs[7] = '{8'h5A, 1'b0, 8'h00, 5'b00000};  // no pad after nonzero

    rst_n = 1'b0;
    bus.poll_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.nes_latch, bus.nes_clk, bus.buttons, bus.up, bus.down, bus.left,
           bus.right, bus.attack, bus.valid, bus.busy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {bus.busy, bus.nes_latch, bus.nes_clk, bus.valid}, 0);

    // ---- table-driven polls ----
    for (int i = 0; i < 8; i++) begin
      run_poll($sformatf("vec%0d", i), vecs[i].pad, vecs[i].conn);
      check($sformatf("vec%0d_buttons", i), bus.buttons, vecs[i].exp_buttons);
      check($sformatf("vec%0d_decodes", i),
            {bus.up, bus.down, bus.left, bus.right, bus.attack}, vecs[i].exp_dec);
      @(negedge clk);
      check($sformatf("vec%0d_valid_one_cycle", i), bus.valid, 0);
      check($sformatf("vec%0d_buttons_hold", i), bus.buttons, vecs[i].exp_buttons);
    end

    // ---- reset in the middle of a HIGH phase ----
    run_poll("pre_reset", 8'h81, 1'b1);
    @(negedge clk);
    pad_bits = 8'h70;
    bus.poll_req = 1'b1;
    @(negedge clk);
    bus.poll_req = 1'b0;
    guard = 0;
    while (!bus.nes_clk && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_high_phase", bus.nes_clk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_poll",
          {bus.nes_latch, bus.nes_clk, bus.buttons, bus.up, bus.down, bus.left,
           bus.right, bus.attack, bus.valid, bus.busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_mid_reset", {bus.busy, bus.nes_latch, bus.nes_clk, bus.valid}, 0);
    run_poll("post_reset", 8'h81, 1'b1);
    check("post_reset_buttons", bus.buttons, 8'h81);
    check("post_reset_decodes", {bus.up, bus.down, bus.left, bus.right, bus.attack}, 5'b00011);
    @(negedge clk);

    // ---- poll_req during a transaction is ignored ----
    pad_bits = 8'h24;
    bus.poll_req = 1'b1;
    @(negedge clk);
    bus.poll_req = 1'b0;
    n_valid = 0; n_rise = 0; prev_latch = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (bus.valid) n_valid++;
      if (bus.nes_latch && !prev_latch) n_rise++;
      prev_latch = bus.nes_latch;
      if (k == 10) bus.poll_req = 1'b1;
      else if (k == 11) bus.poll_req = 1'b0;
      @(negedge clk);
    end
    check("ignored_poll_valids", n_valid, 1);
    check("ignored_poll_latches", n_rise, 1);
    check("ignored_poll_buttons", bus.buttons, 8'h24);

    // ---- poll_req held high: back-to-back polls ----
    pad_bits = 8'h11;
    bus.poll_req = 1'b1;
    n_valid = 0; n_rise = 0; n_idle = 0; prev_latch = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.valid) n_valid++;
      if (!bus.busy) n_idle++;
      if (bus.nes_latch && !prev_latch) n_rise++;
      prev_latch = bus.nes_latch;
    end
    bus.poll_req = 1'b0;
    check("held_poll_valids", n_valid, 2);
    check("held_poll_idle_cycles", n_idle, 2);
    check("held_poll_latches", n_rise, 3);
    guard = 0;
    while (!bus.valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("held_poll_drain", bus.valid, 1);
    check("held_poll_buttons", bus.buttons, 8'h11);
    @(negedge clk);

    // ---- randomized polls against the reference model ----
    for (int i = 0; i < 24; i++) begin
      logic [7:0] bits;
      bit         conn;
      bits  = 8'($urandom);
      conn  = ($urandom_range(0, 3) != 0);
      exp_r = ref_result(bits, conn);
      run_poll($sformatf("rand%0d", i), bits, conn);
      got_r = observed();
      check($sformatf("rand%0d_result_pad%02h_conn%0d", i, bits, conn), got_r, exp_r);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "simulation did not terminate");
  end

endmodule

// File: doc/nes_receiver.md
Name: nes_receiver

Overview:
Serial front end for a standard NES gamepad. It drives the pad's latch and clock lines and shifts in the 8 button bits. It publishes a registered, active-high button word plus decoded up/down/left/right/attack strobes. It sits directly upstream of the InputController in the top level, replacing the tied-off NES_Latch/NES_Clk outputs. One poll is issued per request, normally once per frame from frame_end.

Parameters:
LATCH_CYCLES, 300, width of the nes_latch high pulse in clk cycles (12 us at 25 MHz)
HALF_PERIOD, 150, length of each nes_clk high or low phase in clk cycles (6 us at 25 MHz)

Ports:
clk  input  1  system clock (pixel clock domain)
rst_n  input  1  asynchronous active-low reset
poll_req  input  1  start a read; level or pulse, sampled only in IDLE
nes_data  input  1  serial data from pad, asynchronous, active-low (0 = pressed)
nes_latch  output  1  latch strobe to pad, registered
nes_clk  output  1  shift clock to pad, registered
buttons  output  8  active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
up, down, left, right, attack  output  1 each  decoded from buttons; attack = A
valid  output  1  one-cycle pulse when buttons/decodes update
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE. nes_latch=0, nes_clk=0, buttons=0, all decodes=0, valid=0, busy=0. The shift register, counters and synchroniser clear. This applies immediately, including mid-transaction; no partial result is ever published.
- nes_data passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Phase counter width is $clog2(max(LATCH_CYCLES, HALF_PERIOD)). It counts 0..N-1, and the phase ends when count==N-1.
- State machine:
  - IDLE: when poll_req=1 at an edge, go to LATCH. nes_latch goes to 1 at the next edge. busy=1.
  - LATCH: nes_latch=1 for exactly LATCH_CYCLES cycles. Then go to LOW with bit index 0.
  - LOW: nes_latch=0, nes_clk=0 for HALF_PERIOD cycles.
    - Bit 0 only: in the last cycle, sample ~sync_data into shift bit 0, then go to HIGH with index 1.
    - Index 1..7: this is the post-sample low phase. At its end, index<7 goes to HIGH with index+1; index==7 goes to DONE.
  - HIGH: nes_clk=1 for HALF_PERIOD cycles. In the last cycle, sample ~sync_data into shift bit [index], then go to LOW.
  - DONE: one cycle. Copy the shift register to buttons, update the decodes, assert valid=1, go to IDLE. busy drops the following cycle.
- Pulse count: exactly 7 nes_clk high pulses per poll.
- Latency: valid is high exactly LATCH_CYCLES + 15*HALF_PERIOD + 1 cycles after the edge that accepted poll_req.
- poll_req while busy=1 is ignored and not queued. poll_req held high causes back-to-back polls, with one IDLE cycle between them.
- Decodes:
  - up/down come from buttons[4]/[5]; left/right from [6]/[7].
  - If up and down are both set, both decodes are 0. Same rule for left and right. The raw buttons bits are unmasked.
  - Decodes are registered together with buttons and updated only in DONE.
- buttons and decodes hold their values between polls.
- A disconnected pad reads as data pulled high, giving buttons=8'h00. This is not an error condition.

Test Plan:
(Run with LATCH_CYCLES=4, HALF_PERIOD=2.)
1. Reset mid-transaction: assert rst_n=0 during HIGH state -> nes_latch, nes_clk, valid, busy and buttons are all 0 in the same cycle, with no clk edge needed. After release the FSM is in IDLE; the next poll completes normally.
2. Model a pad returning A+Right (serial bits 0,1,1,1,1,1,1,0) and pulse poll_req -> nes_latch high for exactly 4 cycles, then exactly 7 nes_clk pulses of 2 high/2 low. valid pulses 35 cycles after the poll edge. Result: buttons=8'h81, attack=1, right=1, others 0.
3. Conflicting directions: pad reports Up+Down+Left (8'h70) -> buttons=8'h70, up=0, down=0, left=1, right=0.
4. poll_req pulsed again 10 cycles into a transaction -> ignored; exactly one valid pulse and one latch pulse occur. poll_req held high for 80 cycles -> two complete polls, separated by one IDLE cycle with busy=0.
5. nes_data held at 1 (no pad) -> buttons=8'h00, all decodes 0, valid still pulses at cycle 35. The previous nonzero buttons value holds until that valid.
